// File: rtl/mem_bus_if.sv
// Word-aligned request/response bus between the MEM-stage load/store engine and the APB bridge.
// The master drives the request and receives the completion response.
interface mem_bus_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_strb,
    input  bus_ready, bus_rdata, bus_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_strb,
    output bus_ready, bus_rdata, bus_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one strobed word request per access, stalls the pipeline
// until the bus completes or times out, and returns extended load data.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        transEn,
  input  logic        MemWrite,
  input  logic [1:0]  MemStrobe,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  mem_bus_if.master   bus,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        done,
  output logic        access_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_t;

  state_t          state;
  logic [CntW-1:0] cnt;
  logic [1:0]      off_q;
  logic [1:0]      size_q;
  logic            uns_q;

  logic        is_byte, is_half, is_word, misaligned;
  logic [3:0]  issue_strb;
  logic [31:0] issue_wdata;
  logic [31:0] shifted;
  logic [31:0] extracted;

  // MemStrobe 00 falls into the word case.
  assign is_byte    = (MemStrobe == 2'b01);
  assign is_half    = (MemStrobe == 2'b10);
  assign is_word    = ~is_byte & ~is_half;
  assign misaligned = (is_half & addr[0]) | (is_word & (|addr[1:0]));

  always_comb begin
    issue_strb  = 4'b1111;
    issue_wdata = store_data;
    if (is_byte) begin
      issue_strb  = 4'b0001 << addr[1:0];
      issue_wdata = {4{store_data[7:0]}};
    end else if (is_half) begin
      issue_strb  = 4'b0011 << {addr[1], 1'b0};
      issue_wdata = {2{store_data[15:0]}};
    end
  end

  assign shifted = bus.bus_rdata >> {off_q, 3'b000};

  always_comb begin
    extracted = shifted;
    if (size_q == 2'b01) begin
      extracted = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
    end else if (size_q == 2'b10) begin
      extracted = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
    end
  end

  always_comb begin
    stall = 1'b0;
    unique case (state)
      StIdle:   stall = transEn & ~misaligned;
      StAccess: stall = 1'b1;
      default:  stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= StIdle;
      cnt           <= '0;
      off_q         <= 2'b00;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      bus.req_valid <= 1'b0;
      bus.req_write <= 1'b0;
      bus.req_addr  <= 32'h0;
      bus.req_wdata <= 32'h0;
      bus.req_strb  <= 4'b0000;
      load_data     <= 32'h0;
      done          <= 1'b0;
      access_err    <= 1'b0;
    end else begin
      done       <= 1'b0;
      access_err <= 1'b0;
      unique case (state)
        StIdle: begin
          if (transEn && misaligned) begin
            access_err <= 1'b1;
            load_data  <= 32'h0;
          end else if (transEn) begin
            bus.req_valid <= 1'b1;
            bus.req_write <= MemWrite;
            bus.req_addr  <= {addr[31:2], 2'b00};
            bus.req_wdata <= issue_wdata;
            bus.req_strb  <= MemWrite ? issue_strb : 4'b0000;
            off_q         <= addr[1:0];
            size_q        <= MemStrobe;
            uns_q         <= funct3[2];
            cnt           <= '0;
            state         <= StAccess;
          end
        end
        StAccess: begin
          // A ready on the final counted cycle still completes normally.
          if (bus.bus_ready) begin
            bus.req_valid <= 1'b0;
            load_data     <= bus.req_write ? 32'h0 : extracted;
            done          <= 1'b1;
            access_err    <= bus.bus_err;
            state         <= StDone;
          end else if (cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
            bus.req_valid <= 1'b0;
            load_data     <= 32'h0;
            done          <= 1'b1;
            access_err    <= 1'b1;
            state         <= StDone;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
